// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: write-back has priority, and out-of-order long-latency
// results wait in a small FIFO. A starvation counter forces one async slot when needed.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int ASYNC_DEPTH  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    input  logic                   w_we,
    input  logic [4:0]             w_rd,
    input  logic [XLEN-1:0]        w_data,
    output logic                   w_ready,
    input  logic                   a_valid,
    input  logic [4:0]             a_rd,
    input  logic [XLEN-1:0]        a_data,
    output logic                   a_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [ASYNC_DEPTH:0]   a_pending
);

    localparam int PTR_W = $clog2(ASYNC_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]        fifo_rd_mem   [ASYNC_DEPTH];
    logic [XLEN-1:0]   fifo_data_mem [ASYNC_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]       wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]       rd_ptr_reg, rd_ptr_next;
    logic [ASYNC_DEPTH:0] count_reg, count_next;
    logic [CNT_W-1:0]     starve_reg, starve_next;

    logic            fifo_empty;
    logic            fifo_full;
    logic            pipe_req;
    logic            force_slot;
    logic            grant_pipe;
    logic            grant_async;
    logic            push;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign head_rd    = fifo_rd_mem[rd_ptr_reg[PTR_W-1:0]];
    assign head_data  = fifo_data_mem[rd_ptr_reg[PTR_W-1:0]];

    assign pipe_req   = w_valid & w_we;
    assign force_slot = (starve_reg == CNT_W'(STARVE_LIMIT)) & ~fifo_empty;

    always_comb begin
        grant_pipe  = 1'b0;
        grant_async = 1'b0;
        if (pipe_req && !force_slot) begin
            grant_pipe = 1'b1;
        end else if (!fifo_empty) begin
            grant_async = 1'b1;
        end
    end

    // Write-back only stalls when a forced async slot displaces a real register write.
    assign w_ready   = ~(pipe_req & force_slot);
    assign a_ready   = ~fifo_full;
    assign push      = a_valid & ~fifo_full;
    assign a_pending = count_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + (PTR_W + 1)'(1);
        end
        if (grant_async) begin
            rd_ptr_next = rd_ptr_reg + (PTR_W + 1)'(1);
        end
        count_next = count_reg + (ASYNC_DEPTH + 1)'(push) - (ASYNC_DEPTH + 1)'(grant_async);
    end

    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || grant_async) begin
            starve_next = '0;
        end else if (grant_pipe && starve_reg != CNT_W'(STARVE_LIMIT)) begin
            starve_next = starve_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg[PTR_W-1:0]]   <= a_rd;
            fifo_data_mem[wr_ptr_reg[PTR_W-1:0]] <= a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
        end
    end

    // x0 writes still consume their grant; only the enable is suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_pipe) begin
            rf_we    <= (w_rd != 5'd0);
            rf_waddr <= w_rd;
            rf_wdata <= w_data;
        end else if (grant_async) begin
            rf_we    <= (head_rd != 5'd0);
            rf_waddr <= head_rd;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the write-back stage and a long-latency execution unit (multiply/divide) that returns results out of pipeline order. Async results are held in a small FIFO. The pipeline has priority, but a starvation counter forces an async write slot by back-pressuring write-back. The block sits between write-back, the long-latency unit and the register file, and drives the registered write port.

## Interface
- XLEN, 32: data width.
- ASYNC_DEPTH, 2: async result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive pipeline-won cycles with a non-empty FIFO before an async slot is forced (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- w_valid  in  1  write-back stage holds a valid instruction.
- w_we  in  1  that instruction writes a register (decoded from opcode upstream).
- w_rd  in  5  destination register.
- w_data  in  XLEN  write data.
- w_ready  out  1  write-back may retire this cycle; combinational.
- a_valid  in  1  long-latency unit presents a result.
- a_rd  in  5  result destination.
- a_data  in  XLEN  result data.
- a_ready  out  1  FIFO can accept (= not full); combinational.
- rf_we  out  1  register-file write enable; registered.
- rf_waddr  out  5  write address; registered.
- rf_wdata  out  XLEN  write data; registered.
- a_pending  out  ASYNC_DEPTH+1 bits  FIFO occupancy; registered.

## Operation
- Pipeline request = w_valid & w_we. Async request = FIFO non-empty (head entry).
- Arbitration each cycle:
  - If force = 0 and a pipeline request is present: grant the pipeline, w_ready = 1.
  - If force = 1 and a pipeline request is present: grant async, w_ready = 0 (write-back holds).
  - No pipeline request: grant async if the FIFO is non-empty. w_ready = 1.
  - w_valid & ~w_we never consumes the port. It retires with w_ready = 1 and does not block async.
- force = (starve_cnt == STARVE_LIMIT).
- starve_cnt:
  - Increments when the pipeline is granted while the FIFO is non-empty.
  - Clears when async is granted or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Grant pipeline: next-cycle rf_we = 1, rf_waddr = w_rd, rf_wdata = w_data.
- Grant async: pop the head, next-cycle rf_we = 1 with the head rd/data.
- No grant: rf_we = 0. rf_waddr/rf_wdata hold their previous values.
- rd == 0: the request is granted and consumed normally, but rf_we is forced 0.
- FIFO push on a_valid & a_ready. No bypass around the FIFO.
- Push and pop in the same cycle are allowed at any occupancy except full. When full, a_ready = 0 even if a pop occurs.
- Pointers wrap modulo ASYNC_DEPTH. Occupancy is tracked with an extra bit to distinguish full from empty.
- Async results retire in acceptance order. The pipeline and async streams have no ordering relation enforced here; WAW hazards are prevented upstream by the scoreboard.

## Timing
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, a_pending = 0, FIFO empty, starve_cnt = 0. After reset, w_ready = 1 and a_ready = 1.
- Pipeline write: w_valid & w_we & w_ready at cycle t produces rf_we at t+1.
- Async write minimum latency: accepted at t, head at t+1, earliest rf_we at t+2.
- Forced slot lasts exactly one cycle. On the next cycle the counter is 0 and the pipeline regains priority.
- A held write-back instruction must keep w_rd/w_data stable until w_ready = 1.
- rst asserted mid-operation: FIFO contents are discarded and no rf_we is issued in the cycle after reset. The upstream unit is flushed by the same reset.

## Test plan
- Reset, then pipeline write rd=5 data=0x1234 at t -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at t+1; a_pending=0.
- Idle pipeline, async rd=7 data=0xAA accepted at t -> a_pending=1 at t+1, rf_we with rd=7/0xAA at t+2, a_pending=0 at t+2.
- Continuous pipeline writes, one async entry, STARVE_LIMIT=4 -> four pipeline writes, then w_ready=0 for one cycle and the async write lands, then the pipeline resumes. Verify no pipeline write is lost.
- Fill FIFO with 2 async results while the pipeline writes every cycle -> a_ready=0, a_pending=2. A third a_valid is held until a pop, and entries retire in FIFO order.
- Pipeline w_we=0 with FIFO non-empty -> w_ready=1 and the async entry is written that cycle. Separately, a pipeline write to rd=0 -> w_ready=1 and rf_we=0.
- rst asserted with 2 FIFO entries -> no rf_we the following cycle, a_pending=0, a_ready=1.
